// File: rtl/input_adapter_high_perf_if.sv
// Host-side and core-side word streams of the input adapter.
// master = host/core environment, slave = the adapter itself.
interface input_adapter_high_perf_if;
  logic        valid_i;
  logic        ready_i;
  logic [63:0] data_i;
  logic        valid_o;
  logic        ready_o;
  logic [63:0] data_o;
  logic        last_o;

  modport master (output valid_i, data_i, ready_o,
                  input  ready_i, valid_o, data_o, last_o);
  modport slave  (input  valid_i, data_i, ready_o,
                  output ready_i, valid_o, data_o, last_o);
endinterface

// File: rtl/input_adapter_high_perf.sv
// Frames one Dilithium operation's host words toward the core through a
// 2-entry skid buffer, tags the final word and blocks input until next start.
module input_adapter_high_perf (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] mode,
  input  logic [2:0] sec_lvl,
  input_adapter_high_perf_if.slave bus,
  output logic       busy,
  output logic       done,
  output logic       err
);
  typedef enum logic [1:0] {S_IDLE, S_HDR, S_BODY, S_DRAIN} state_t;

  state_t        r_state, w_next;
  logic [1:0]    r_mode;
  logic [2:0]    r_lvl;
  logic [32:0]   r_rem, w_hdr_rem;
  logic [1:0][64:0] r_mem;   // {last, data}
  logic          r_rd, r_wr;
  logic [1:0]    r_cnt;
  logic          r_done, r_err, w_done_nxt, w_err_nxt;
  logic          w_legal, w_push, w_pop, w_ready, w_last;

  function automatic logic [32:0] f_sk(input logic [2:0] l);
    case (l)
      3'd2:    f_sk = 33'd318;
      3'd3:    f_sk = 33'd502;
      default: f_sk = 33'd610;
    endcase
  endfunction

  function automatic logic [32:0] f_pk(input logic [2:0] l);
    case (l)
      3'd2:    f_pk = 33'd164;
      3'd3:    f_pk = 33'd244;
      default: f_pk = 33'd324;
    endcase
  endfunction

  function automatic logic [32:0] f_sig(input logic [2:0] l);
    case (l)
      3'd2:    f_sig = 33'd303;
      3'd3:    f_sig = 33'd412;
      default: f_sig = 33'd575;
    endcase
  endfunction

  assign w_legal = (mode != 2'd3) &&
                   (sec_lvl == 3'd2 || sec_lvl == 3'd3 || sec_lvl == 3'd5);
  assign w_pop   = (r_cnt != 2'd0) && bus.ready_o;
  // ready_i depends on state, fill level and the core's ready, never on valid_i
  assign w_ready = (r_state == S_HDR || r_state == S_BODY) &&
                   ((r_cnt != 2'd2) || w_pop);
  assign w_push  = bus.valid_i && w_ready;
  assign w_last  = (r_state == S_BODY) && (r_rem == 33'd1);
  assign w_hdr_rem = (r_mode == 2'd1) ?
                     f_sk(r_lvl) + {1'b0, bus.data_i[31:0]} :
                     f_pk(r_lvl) + f_sig(r_lvl) + {1'b0, bus.data_i[31:0]};

  assign bus.ready_i = w_ready;
  assign bus.valid_o = (r_cnt != 2'd0);
  assign bus.data_o  = r_mem[r_rd][63:0];
  assign bus.last_o  = (r_cnt != 2'd0) && r_mem[r_rd][64];
  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;
  assign err         = r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_done_nxt = 1'b0;
    w_err_nxt  = 1'b0;
    case (r_state)
      S_IDLE:
        if (start) begin
          if (!w_legal)           w_err_nxt = 1'b1;
          else if (mode == 2'd0)  w_next = S_BODY;
          else                    w_next = S_HDR;
        end
      S_HDR:  if (w_push) w_next = S_BODY;
      S_BODY: if (w_push && w_last) w_next = S_DRAIN;
      S_DRAIN:
        // leave as the last word is popped so done and busy-low coincide
        if (r_cnt == 2'd0 || (r_cnt == 2'd1 && w_pop)) begin
          w_next     = S_IDLE;
          w_done_nxt = 1'b1;
        end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rem  <= '0;
      r_mode <= '0;
      r_lvl  <= '0;
    end else if (r_state == S_IDLE && start && w_legal) begin
      r_mode <= mode;
      r_lvl  <= sec_lvl;
      r_rem  <= (mode == 2'd0) ? 33'd4 : 33'd0;
    end else if (w_push) begin
      r_rem  <= (r_state == S_HDR) ? w_hdr_rem : r_rem - 33'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem <= '0;
      r_rd  <= 1'b0;
      r_wr  <= 1'b0;
      r_cnt <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= {w_last, bus.data_i};
        r_wr        <= ~r_wr;
      end
      if (w_pop) r_rd <= ~r_rd;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end
endmodule

// File: tb/tb_input_adapter_high_perf.sv
// Scoreboard bench: frames are queued with their expected core-side words;
// a negedge monitor pops and compares every core transfer.
module tb_input_adapter_high_perf;
  logic       clk = 1'b0;
  logic       rst, start;
  logic [1:0] mode;
  logic [2:0] sec_lvl;
  logic       busy, done, err;

  input_adapter_high_perf_if bus();

  input_adapter_high_perf dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .sec_lvl(sec_lvl),
    .bus(bus), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int          n_chk = 0, n_fail = 0, cyc = 0, acc_cnt = 0, last_cyc = -10;
  logic [64:0] sb_q[$];
  logic [63:0] hq[$];
  logic [64:0] exp_w;
  logic [63:0] stall_data;
  bit          rnd_rdy = 1'b0, stall_prev = 1'b0, drv_acc;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // host driver: presents hq head, retires it once accepted
  initial begin
    bus.valid_i = 1'b0;
    bus.data_i  = '0;
    forever begin
      @(negedge clk);
      drv_acc = bus.valid_i && bus.ready_i;
      @(posedge clk); #1;
      if (drv_acc && hq.size() > 0) begin
        void'(hq.pop_front());
        acc_cnt++;
      end
      bus.valid_i = (hq.size() > 0);
      bus.data_i  = (hq.size() > 0) ? hq[0] : 64'h0;
    end
  end

  initial begin
    bus.ready_o = 1'b1;
    forever begin
      @(posedge clk); #1;
      bus.ready_o = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // core-side monitor
  always @(negedge clk) begin
    if (stall_prev) begin
      chk("stall_valid", {63'd0, bus.valid_o}, 64'd1);
      chk("stall_data", bus.data_o, stall_data);
    end
    stall_prev = bus.valid_o && !bus.ready_o && !rst;
    stall_data = bus.data_o;
    if (bus.valid_o && bus.ready_o) begin
      if (sb_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_word: got %0h expected none", bus.data_o);
      end else begin
        exp_w = sb_q.pop_front();
        chk("out_data", bus.data_o, exp_w[63:0]);
        chk("out_last", {63'd0, bus.last_o}, {63'd0, exp_w[64]});
        if (bus.last_o) last_cyc = cyc;
      end
    end
  end

  task automatic chk_reset(input string nm);
    chk({nm, "_ready_i"}, {63'd0, bus.ready_i}, 64'd0);
    chk({nm, "_valid_o"}, {63'd0, bus.valid_o}, 64'd0);
    chk({nm, "_data_o"},  bus.data_o, 64'd0);
    chk({nm, "_last_o"},  {63'd0, bus.last_o}, 64'd0);
    chk({nm, "_busy"},    {63'd0, busy}, 64'd0);
    chk({nm, "_done"},    {63'd0, done}, 64'd0);
    chk({nm, "_err"},     {63'd0, err}, 64'd0);
  endtask

  task automatic do_start(input logic [1:0] m, input logic [2:0] l);
    @(posedge clk); #1;
    mode = m; sec_lvl = l; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // queues the frame on both sides, plus one trailing word that must never be taken
  task automatic load_frame(input logic [63:0] hdr, input bit has_hdr,
                            input int n_body, input logic [63:0] base);
    logic [63:0] w;
    acc_cnt = 0;
    if (has_hdr) begin
      hq.push_back(hdr);
      sb_q.push_back({1'b0, hdr});
    end
    for (int i = 0; i < n_body; i++) begin
      w = base + 64'(i);
      hq.push_back(w);
      sb_q.push_back({(i == n_body - 1) ? 1'b1 : 1'b0, w});
    end
    hq.push_back(64'hBAD0_0000_0000_0005);
  endtask

  task automatic wait_done(input string nm, input int exp_len, input int limit);
    int dn = 0;
    int c  = 0;
    while (dn == 0 && c < limit) begin
      @(negedge clk); c++;
      if (acc_cnt >= exp_len)
        chk({nm, "_rdy_after_last"}, {63'd0, bus.ready_i}, 64'd0);
      if (done) begin
        dn++;
        chk({nm, "_done_lat"}, 64'(cyc), 64'(last_cyc + 1));
        chk({nm, "_busy_at_done"}, {63'd0, busy}, 64'd0);
      end
    end
    if (dn == 0) begin
      n_chk++; n_fail++;
      $display("FAIL %s_timeout: got no done expected done within %0d cycles", nm, limit);
    end
    repeat (5) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk({nm, "_done_cnt"}, 64'(dn), 64'd1);
    chk({nm, "_acc_cnt"}, 64'(acc_cnt), 64'(exp_len));
    chk({nm, "_sb_empty"}, 64'(sb_q.size()), 64'd0);
    hq.delete();
    @(posedge clk); #2;
  endtask

  task automatic err_case(input string nm, input logic [1:0] m, input logic [2:0] l);
    do_start(m, l);
    @(negedge clk);
    chk({nm, "_err"}, {63'd0, err}, 64'd1);
    chk({nm, "_busy"}, {63'd0, busy}, 64'd0);
    chk({nm, "_ready_i"}, {63'd0, bus.ready_i}, 64'd0);
    chk({nm, "_valid_o"}, {63'd0, bus.valid_o}, 64'd0);
    @(negedge clk);
    chk({nm, "_err_pulse"}, {63'd0, err}, 64'd0);
    chk({nm, "_busy2"}, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    rst = 1'b1; start = 1'b0; mode = 2'd0; sec_lvl = 3'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset("rst");
    @(posedge clk); #2; rst = 1'b0;

    // keygen, sec_lvl 2
    load_frame(64'd0, 1'b0, 4, 64'h1);
    do_start(2'd0, 3'd2);
    @(negedge clk);
    chk("kg_busy", {63'd0, busy}, 64'd1);
    chk("kg_ready_i", {63'd0, bus.ready_i}, 64'd1);
    wait_done("kg", 4, 100);

    // sign, sec_lvl 3, MLEN 2 -> 505 words
    load_frame({32'hA5A5_0001, 32'd2}, 1'b1, 504, 64'h1000);
    do_start(2'd1, 3'd3);
    wait_done("sign", 505, 2000);

    // verify, sec_lvl 5, MLEN 0 -> 900 words, core ready random
    rnd_rdy = 1'b1;
    load_frame({32'hFFFF_FFFF, 32'd0}, 1'b1, 899, 64'h2_0000);
    do_start(2'd2, 3'd5);
    wait_done("ver", 900, 6000);
    rnd_rdy = 1'b0;
    repeat (2) @(posedge clk);

    err_case("err_lvl4", 2'd1, 3'd4);
    err_case("err_mode3", 2'd3, 3'd2);

    // reset at word 100 of a sign frame
    load_frame({32'h0, 32'd5}, 1'b1, 323, 64'h3000);
    do_start(2'd1, 3'd2);
    c = 0;
    while (acc_cnt < 100 && c < 400) begin
      @(posedge clk); #2; c++;
    end
    chk("mid_reached_100", 64'(acc_cnt), 64'd100);
    rst = 1'b1;
    #1;
    chk_reset("mid_rst");
    hq.delete(); sb_q.delete(); acc_cnt = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("mid_no_done", {63'd0, done}, 64'd0);
    @(posedge clk); #2; rst = 1'b0;
    load_frame(64'd0, 1'b0, 4, 64'h50);
    do_start(2'd0, 3'd3);
    wait_done("post_rst_kg", 4, 100);

    // stray start during keygen BODY is ignored
    load_frame(64'd0, 1'b0, 4, 64'h40);
    do_start(2'd0, 3'd2);
    do_start(2'd1, 3'd3);
    wait_done("kg_stray", 4, 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/input_adapter_high_perf.md
# input_adapter_high_perf

Host-side input framing stage for the high-performance Dilithium top. It sits between the host 64-bit stream and `combined_top`'s input port. It latches `mode`/`sec_lvl` on `start` and forwards exactly one operation's worth of input words through a 2-entry registered skid buffer. It marks the final word with `last_o`, then blocks further host input until the next `start`.

## Interface
- No parameters; word counts are fixed by the tables under Operation.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle pulse; begins a frame, sampled only in IDLE.
- `mode` in 2: 0 keygen, 1 sign, 2 verify, 3 illegal; sampled with `start`.
- `sec_lvl` in 3: 2, 3 or 5 are legal; sampled with `start`.
- `valid_i` in 1: host word valid.
- `ready_i` out 1: block accepts a host word.
- `data_i` in 64: host word.
- `valid_o` out 1: word valid toward core.
- `ready_o` in 1: core accepts a word.
- `data_o` out 64: word toward core.
- `last_o` out 1: qualifies `data_o`; high on the frame's final word.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse when the final word has been accepted by the core.
- `err` out 1: one-cycle pulse when `start` arrives with an illegal mode or sec_lvl.

## Operation
- Frame layouts (all words forwarded unchanged, including the header):
  - keygen: 4 seed words, no header.
  - sign: header, then SK words, then MLEN message words.
  - verify: header, then PK words, then SIG words, then MLEN message words.
- Header: MLEN = `data_i[31:0]`; bits 63:32 are ignored by this block.
- Fixed word counts, by sec_lvl 2/3/5:
  - SK: 318 / 502 / 610.
  - PK: 164 / 244 / 324.
  - SIG: 303 / 412 / 575.
- Total frame length:
  - keygen: 4.
  - sign: 1 + SK + MLEN.
  - verify: 1 + PK + SIG + MLEN.
- Remaining-word counter: 33 bits, unsigned, no wrap possible. It is loaded at `start`, or at header acceptance for sign/verify, and decrements on each accepted host word.
- States:
  - IDLE: `ready_i`=0.
    - `start` with legal inputs → HDR (sign/verify) or BODY (keygen; remaining=4).
    - `start` with illegal inputs → `err` pulse, stay in IDLE.
  - HDR: the first accepted word is the header. Load remaining = total − 1, then go to BODY.
  - BODY: accept words until remaining reaches 0. The word taking remaining 1→0 is tagged last; then go to DRAIN.
  - DRAIN: `ready_i`=0. When the skid buffer is empty (last word taken by the core), pulse `done` and go to IDLE.
- Skid buffer: 2-entry FIFO of {data, last}.
  - `valid_o` = FIFO not empty; `data_o`/`last_o` are the FIFO head.
  - `ready_i` = state ∈ {HDR, BODY} and FIFO count < 2, or count = 2 with a pop this cycle. `ready_i` is registered-equivalent (no combinational path from `valid_i`).
- `start` outside IDLE: ignored; no `err`, no state change.

## Timing
- Reset values: `ready_i`=0, `valid_o`=0, `data_o`=0, `last_o`=0, `busy`=0, `done`=0, `err`=0; state IDLE, FIFO empty, counter 0.
- Reset mid-frame: FIFO is flushed and the frame is abandoned; no `done`.
- `start` at cycle t: `busy` and `ready_i` go high at t+1.
- `err` is asserted at t+1 for one cycle.
- Host word accepted at edge t: appears on `data_o` at t+1 when the FIFO is empty and not blocked.
- Throughput: 1 word/cycle when `ready_o` is held high.
- Core handshake: transfer when `valid_o && ready_o`. `data_o`/`last_o` stay stable while `valid_o && !ready_o`.
- Simultaneous push and pop with count=2: both occur; count stays 2.
- `done` is asserted the cycle after the core accepts the `last_o` word. `busy` falls in the same cycle as `done`.
- No host word is accepted after the last word until a new `start`, even if `valid_i` stays high.

## Test plan
- Keygen, sec_lvl 2, `ready_o`=1, 4 words 0x1..0x4 → `data_o` 0x1..0x4 on consecutive cycles. `last_o` is set only with 0x4. `done` pulses one cycle after 0x4 is accepted. A 5th host word is never accepted.
- Sign, sec_lvl 3, header MLEN=2 → 505 words forwarded in order; `last_o` on word 505 only; `ready_i`=0 from then until `done`.
- Verify, sec_lvl 5, MLEN=0, `ready_o` toggling pseudo-randomly → 900 words forwarded with no loss or duplication. `data_o` holds stable during stalls. `last_o` on word 900.
- `start` with sec_lvl=4, and separately mode=3 → `err` pulses once each; `busy`, `ready_i` and `valid_o` stay 0.
- `rst` asserted at word 100 of a sign frame → all outputs return to reset values immediately. A subsequent keygen frame completes correctly.
- `start` pulsed during BODY of a keygen frame → ignored. The frame completes with exactly 4 words and one `done`.
